// File: rtl/theremin_period_pkg.sv
// rtl/theremin_period_pkg.sv - shared types and helpers for the theremin period window averager
package theremin_period_pkg;

  typedef enum logic {FILL, RUN} state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1 << 20;

  function automatic logic [7:0] clamp_win(input logic [7:0] win, input logic [7:0] max_win);
    return (win > max_win) ? max_win : win;
  endfunction

endpackage

// File: rtl/theremin_halfperiod_ring.sv
// rtl/theremin_halfperiod_ring.sv - half-period ring buffer with combinational read of the evicted sample
module theremin_halfperiod_ring
  import theremin_period_pkg::*;
#(
  parameter int HALF_BITS  = 15,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK_PARALLEL,
  input  logic                  RESET,
  input  logic                  wr_en,
  input  logic [HALF_BITS-1:0]  wr_data,
  input  logic [DEPTH_LOG2:0]   win,
  output logic [HALF_BITS-1:0]  rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int WB    = DEPTH_LOG2 + 1;

  logic [HALF_BITS-1:0] ring [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_idx;

  // Slot written 2^win accepts ago; for the full window this is wr_ptr itself.
  always_comb rd_idx = PW'({1'b0, wr_ptr} - (WB'(1) << win));

  assign rd_data = ring[rd_idx];

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
      wr_ptr       <= wr_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/theremin_period_window_avg.sv
// rtl/theremin_period_window_avg.sv - sliding-window full-period estimator; optional idle timeout via THEREMIN_PERIOD_TIMEOUT_EN
module theremin_period_window_avg
  import theremin_period_pkg::*;
#(
  parameter int HALF_BITS  = 15,
  parameter int DEPTH_LOG2 = 3,
  parameter int SUM_BITS   = HALF_BITS + DEPTH_LOG2
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                  CLK_PARALLEL,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  HALF_VALID,
  input  logic [HALF_BITS-1:0]  HALF_PERIOD,
  input  logic [DEPTH_LOG2:0]   WIN_LOG2,
  output logic                  CHANGE_FLAG,
  output logic [SUM_BITS-1:0]   SUM,
  output logic [HALF_BITS:0]    PERIOD,
  output logic                  WINDOW_FULL,
  output logic                  NO_SIGNAL
);

  localparam int WB = DEPTH_LOG2 + 1;
  localparam int PB = HALF_BITS + 1;

  state_t               state;
  logic [SUM_BITS-1:0]  sum;
  logic [WB-1:0]        fill_cnt;
  logic [WB-1:0]        win_q;
  logic [HALF_BITS-1:0] ring_old;

  logic [WB-1:0]        win_c;
  logic [WB-1:0]        span;
  logic [WB-1:0]        cnt_fill;
  logic [SUM_BITS-1:0]  sample;
  logic [SUM_BITS-1:0]  sum_fill;
  logic [SUM_BITS-1:0]  sum_run;
  logic [SUM_BITS-1:0]  sum_next;
  logic [PB-1:0]        period_next;
  logic                 win_chg;
  logic                 accept;
  logic                 in_run;
  logic                 fill_done;

  always_comb begin
    win_c     = WB'(clamp_win(8'(WIN_LOG2), 8'(DEPTH_LOG2)));
    win_chg   = (win_c != win_q);
    accept    = CE && HALF_VALID;
    sample    = SUM_BITS'(HALF_PERIOD);
    span      = WB'(1) << win_c;
    // A sample arriving with a window change starts the new fill.
    sum_fill  = (win_chg ? '0 : sum) + sample;
    cnt_fill  = (win_chg ? '0 : fill_cnt) + WB'(1);
    fill_done = (cnt_fill == span);
    sum_run   = sum + sample - SUM_BITS'(ring_old);
    in_run    = (state == RUN) && !win_chg;
    sum_next  = in_run ? sum_run : sum_fill;
    period_next = PB'({sum_next, 1'b0} >> win_c);
  end

  theremin_halfperiod_ring #(
    .HALF_BITS  (HALF_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ring (
    .CLK_PARALLEL (CLK_PARALLEL),
    .RESET        (RESET),
    .wr_en        (accept),
    .wr_data      (HALF_PERIOD),
    .win          (win_c),
    .rd_data      (ring_old)
  );

`ifdef THEREMIN_PERIOD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  logic [IDLE_W-1:0] idle_cnt;
`else
  assign NO_SIGNAL = 1'b0;
`endif

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      state       <= FILL;
      sum         <= '0;
      fill_cnt    <= '0;
      win_q       <= '0;
      CHANGE_FLAG <= 1'b0;
      SUM         <= '0;
      PERIOD      <= '0;
      WINDOW_FULL <= 1'b0;
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
      idle_cnt    <= '0;
      NO_SIGNAL   <= 1'b0;
`endif
    end else begin
      CHANGE_FLAG <= 1'b0;
      if (CE) begin
        win_q <= win_c;
        if (win_chg) begin
          state       <= FILL;
          WINDOW_FULL <= 1'b0;
          sum         <= '0;
          fill_cnt    <= '0;
        end
`ifdef THEREMIN_PERIOD_TIMEOUT_EN
        if (accept) begin
          idle_cnt  <= '0;
          NO_SIGNAL <= 1'b0;
        end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end else if (!NO_SIGNAL) begin
          NO_SIGNAL   <= 1'b1;
          state       <= FILL;
          WINDOW_FULL <= 1'b0;
          sum         <= '0;
          fill_cnt    <= '0;
        end
`endif
        if (accept) begin
          if (in_run) begin
            sum         <= sum_run;
            SUM         <= sum_next;
            PERIOD      <= period_next;
            CHANGE_FLAG <= 1'b1;
          end else begin
            sum      <= sum_fill;
            fill_cnt <= cnt_fill;
            if (fill_done) begin
              state       <= RUN;
              WINDOW_FULL <= 1'b1;
              SUM         <= sum_next;
              PERIOD      <= period_next;
              CHANGE_FLAG <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
